chunked_addsub_unit: RTL

- Parametrised multi-cycle adder/subtractor. It is the successor to the fixed 4-bit ripple adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through one ripple chunk adder, carrying between cycles.
- Returns sum, carry-out, signed overflow and zero flags.
- Sits between the ALU operand registers and the result writeback. Uses valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 13 +
 rtl/chunked_addsub_unit_if.sv | 39 +++
 rtl/chunked_addsub_unit_chunk_adder.sv | 29 ++
 rtl/chunked_addsub_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and the chunked adder FSM states.
package alu_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/chunked_addsub_unit_if.sv
// Operand request / result handshake bundle for chunked_addsub_unit.
// The sat field exists only when CHUNKED_ADDSUB_SATURATE_EN is defined.
interface chunked_addsub_unit_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op;
`ifdef CHUNKED_ADDSUB_SATURATE_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output
`ifdef CHUNKED_ADDSUB_SATURATE_EN
             sat,
`endif
             in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, s, cout, ovf, zero
   );

   modport slave (
      input
`ifdef CHUNKED_ADDSUB_SATURATE_EN
             sat,
`endif
             in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, s, cout, ovf, zero
   );

endinterface

// File: rtl/chunked_addsub_unit_chunk_adder.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into
// the MSB so the caller can derive signed overflow.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [CHUNK:0] c;

   always_comb begin
      sum  = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[CHUNK];
   assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub_unit.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one ripple adder.
// Optional result clamping on signed overflow: CHUNKED_ADDSUB_SATURATE_EN.
module chunked_addsub_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   chunked_addsub_unit_if.slave bus
);

   localparam int              NCHUNK = WIDTH / CHUNK;
   localparam int              IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST   = IDXW'(NCHUNK - 1);

   state_t           state;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic             carry;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
`ifdef CHUNKED_ADDSUB_SATURATE_EN
   logic             sat_q;
`endif

   logic [CHUNK-1:0] a_c;
   logic [CHUNK-1:0] b_c;
   logic [CHUNK-1:0] sum_c;
   logic             co_c;
   logic             cm_c;
   logic             ovf_c;
   logic [WIDTH-1:0] s_next;
   logic [WIDTH-1:0] s_fin;

`ifdef CHUNKED_ADDSUB_SATURATE_EN
   function automatic logic [WIDTH-1:0] sat_clamp(input logic neg);
      sat_clamp = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   assign a_c = a_q[idx*CHUNK +: CHUNK];
   assign b_c = b_q[idx*CHUNK +: CHUNK];

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_c),
      .b    (b_c),
      .cin  (carry),
      .sum  (sum_c),
      .cout (co_c),
      .cmsb (cm_c)
   );

   // s_next is s with the current chunk merged in; only meaningful as the
   // full result on the final chunk.
   always_comb begin
      s_next                     = s_q;
      s_next[idx*CHUNK +: CHUNK] = sum_c;
      ovf_c                      = co_c ^ cm_c;
      s_fin                      = s_next;
`ifdef CHUNKED_ADDSUB_SATURATE_EN
      if (sat_q && ovf_c)
         s_fin = sat_clamp(a_q[WIDTH-1]);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.a;
                  b_q   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                  carry <= (bus.op == OP_SUB) ? 1'b1 : bus.cin;
`ifdef CHUNKED_ADDSUB_SATURATE_EN
                  sat_q <= bus.sat;
`endif
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               carry <= co_c;
               if (idx == LAST) begin
                  s_q    <= s_fin;
                  cout_q <= co_c;
                  ovf_q  <= ovf_c;
                  zero_q <= (s_fin == '0);
                  state  <= DONE;
               end else begin
                  s_q <= s_next;
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = rst_n && (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.s         = s_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

endmodule
